// File: rtl/storage_pkg.sv
// Shared types for the storage controller: FSM states, address regions and the region decoder.
package storage_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSram,
        StResp,
        StFill,
        StProgDrain,
        StProg
    } state_e;

    typedef enum logic [1:0] {
        REG_SRAM,
        REG_FLASH,
        REG_ERR
    } region_e;

    // 64-bit compares so a window touching the top of the address space cannot wrap.
    function automatic region_e decode(input logic [31:0] addr, input int unsigned sram_aw,
                                       input logic [31:0] flash_base,
                                       input int unsigned flash_aw);
        logic [63:0] a;
        logic [63:0] sram_size;
        logic [63:0] fl_lo;
        logic [63:0] fl_hi;
        a         = {32'd0, addr};
        sram_size = 64'd4 << sram_aw;
        fl_lo     = {32'd0, flash_base};
        fl_hi     = fl_lo + (64'd4 << flash_aw);
        if (a < sram_size) begin
            return REG_SRAM;
        end
        if (a >= fl_lo && a < fl_hi) begin
            return REG_FLASH;
        end
        return REG_ERR;
    endfunction

endpackage

// File: rtl/storage_cache_array.sv
// Direct-mapped read-cache storage: valid/tag/data flops, one write port, combinational read.
module storage_cache_array
    import storage_pkg::*;
#(
    parameter int unsigned NUM_LINES  = 16,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned TAG_W      = 16,
    localparam int unsigned IW = $clog2(NUM_LINES),
    localparam int unsigned OW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_all,
    input  logic [IW-1:0]    rd_index,
    input  logic [OW-1:0]    rd_offset,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_data,
    input  logic             wr_en,
    input  logic [IW-1:0]    wr_index,
    input  logic [OW-1:0]    wr_offset,
    input  logic [31:0]      wr_data,
    input  logic             install,
    input  logic [TAG_W-1:0] install_tag
);

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [31:0]          data_q [NUM_LINES][LINE_WORDS];

    // A line being refilled is invalid until its last word lands.
    always_ff @(posedge clk) begin
        if (!rst || flush_all) begin
            valid_q <= '0;
        end else if (install) begin
            valid_q[wr_index] <= 1'b1;
        end else if (wr_en) begin
            valid_q[wr_index] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (install) begin
            tag_q[wr_index] <= install_tag;
        end
        if (wr_en) begin
            data_q[wr_index][wr_offset] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index][rd_offset];

endmodule

// File: rtl/storage_cache_ctrl.sv
// Request port fronting scratchpad SRAM and cached SPI flash, with a flash programming hand-off.
module storage_cache_ctrl
    import storage_pkg::*;
#(
    parameter int unsigned SRAM_AW    = 11,
    parameter logic [31:0] FLASH_BASE = 32'h0001_0000,
    parameter int unsigned FLASH_AW   = 22,
    parameter int unsigned NUM_LINES  = 16,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [31:0]         req_addr,
    input  logic [31:0]         req_wdata,
    input  logic [3:0]          req_be,
    output logic                resp_valid,
    output logic [31:0]         resp_rdata,
    output logic                resp_err,
    input  logic                cache_flush,
    input  logic                prog_mode,
    output logic                prog_active,
    output logic                sram_cen_n,
    output logic                sram_gwen_n,
    output logic [3:0]          sram_wen_n,
    output logic [SRAM_AW-1:0]  sram_a,
    output logic [31:0]         sram_d,
    input  logic [31:0]         sram_q,
    output logic                wb_cyc,
    output logic                wb_stb,
    output logic [FLASH_AW-1:0] wb_addr,
    input  logic                wb_stall,
    input  logic                wb_ack,
    input  logic [31:0]         wb_data,
    input  logic                fl_cs_n_i,
    input  logic                fl_sck_i,
    input  logic                fl_mosi_i,
    output logic                fl_cs_n,
    output logic                fl_sck,
    output logic                fl_mosi,
    input  logic                fl_miso,
    input  logic                pg_cs_n,
    input  logic                pg_sck,
    input  logic                pg_mosi,
    output logic                pg_miso
);

    localparam int unsigned IW = $clog2(NUM_LINES);
    localparam int unsigned OB = $clog2(LINE_WORDS);
    localparam int unsigned OW = (LINE_WORDS > 1) ? OB : 1;
    localparam int unsigned TW = FLASH_AW - IW - OB;

    state_e state_q, state_d;

    region_e             region;
    logic                accept;
    logic                hit;
    logic                flush_now;
    logic [31:0]         faddr;
    logic [FLASH_AW-1:0] fword;
    logic [TW-1:0]       req_tag;
    logic [IW-1:0]       req_index;
    logic [OW-1:0]       req_offset;

    logic                we_q;
    logic                err_q;
    logic [31:0]         rdata_q;
    logic [TW-1:0]       tag_q;
    logic [IW-1:0]       index_q;
    logic [OW-1:0]       offset_q;
    logic [OW-1:0]       cnt_q;
    logic                issued_q;
    logic                flush_pend_q;

    logic                stb_out;
    logic                issued;
    logic                take;
    logic                last;
    logic                rd_valid;
    logic [TW-1:0]       rd_tag;
    logic [31:0]         rd_data;

    assign region     = decode(req_addr, SRAM_AW, FLASH_BASE, FLASH_AW);
    assign faddr      = req_addr - FLASH_BASE;
    assign fword      = FLASH_AW'(faddr >> 2);
    assign req_offset = OW'(fword & FLASH_AW'(LINE_WORDS - 1));
    assign req_index  = IW'(fword >> OB);
    assign req_tag    = TW'(fword >> (OB + IW));

    assign req_ready = rst && (state_q == StIdle) && !prog_mode;
    assign accept    = req_valid && req_ready;

    // Pending flushes and programming exit both invalidate before any lookup can hit.
    assign flush_now = ((state_q == StIdle) && (cache_flush || flush_pend_q)) ||
                       ((state_q == StProg) && !prog_mode);
    assign hit       = (region == REG_FLASH) && !req_we && rd_valid && !flush_now &&
                       (rd_tag == req_tag);

    // One outstanding wishbone read: stb until not stalled, then wait for ack.
    assign stb_out = (state_q == StFill) && !issued_q;
    assign issued  = issued_q || (stb_out && !wb_stall);
    assign take    = (state_q == StFill) && wb_ack && issued;
    assign last    = (cnt_q == OW'(LINE_WORDS - 1));

    storage_cache_array #(
        .NUM_LINES (NUM_LINES),
        .LINE_WORDS(LINE_WORDS),
        .TAG_W     (TW)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .flush_all  (flush_now),
        .rd_index   (req_index),
        .rd_offset  (req_offset),
        .rd_valid   (rd_valid),
        .rd_tag     (rd_tag),
        .rd_data    (rd_data),
        .wr_en      (take),
        .wr_index   (index_q),
        .wr_offset  (cnt_q),
        .wr_data    (wb_data),
        .install    (take && last),
        .install_tag(tag_q)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (prog_mode) begin
                    state_d = StProgDrain;
                end else if (req_valid) begin
                    case (region)
                        REG_SRAM:  state_d = StSram;
                        REG_FLASH: state_d = (req_we || hit) ? StResp : StFill;
                        default:   state_d = StResp;
                    endcase
                end
            end
            StSram, StResp: state_d = prog_mode ? StProgDrain : StIdle;
            StFill: begin
                if (take && last) begin
                    state_d = StResp;
                end
            end
            // Wait for spixpress to release chip select before swapping the pins.
            StProgDrain: begin
                if (!prog_mode) begin
                    state_d = StIdle;
                end else if (fl_cs_n_i) begin
                    state_d = StProg;
                end
            end
            StProg: begin
                if (!prog_mode) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
            tag_q        <= '0;
            index_q      <= '0;
            offset_q     <= '0;
            cnt_q        <= '0;
            issued_q     <= 1'b0;
            flush_pend_q <= 1'b0;
        end else begin
            if (state_q == StIdle) begin
                flush_pend_q <= 1'b0;
            end else if (cache_flush) begin
                flush_pend_q <= 1'b1;
            end
            if (accept) begin
                we_q     <= req_we;
                tag_q    <= req_tag;
                index_q  <= req_index;
                offset_q <= req_offset;
                cnt_q    <= '0;
                issued_q <= 1'b0;
                err_q    <= (region == REG_ERR) || ((region == REG_FLASH) && req_we);
                rdata_q  <= hit ? rd_data : '0;
            end else if (state_q == StFill) begin
                if (take) begin
                    issued_q <= 1'b0;
                    cnt_q    <= cnt_q + OW'(1);
                    if (cnt_q == offset_q) begin
                        rdata_q <= wb_data;
                    end
                end else if (issued) begin
                    issued_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        resp_valid  = rst && ((state_q == StSram) || (state_q == StResp));
        resp_err    = rst && (state_q == StResp) && err_q;
        resp_rdata  = '0;
        if (rst && (state_q == StSram) && !we_q) begin
            resp_rdata = sram_q;
        end else if (rst && (state_q == StResp)) begin
            resp_rdata = rdata_q;
        end

        sram_cen_n  = !(accept && (region == REG_SRAM));
        sram_gwen_n = !(accept && (region == REG_SRAM) && req_we);
        sram_wen_n  = (accept && (region == REG_SRAM) && req_we) ? ~req_be : 4'hF;
        sram_a      = req_addr[SRAM_AW+1:2];
        sram_d      = req_wdata;

        wb_cyc      = rst && (state_q == StFill);
        wb_stb      = rst && stb_out;
        wb_addr     = (FLASH_AW'(tag_q) << (OB + IW)) | (FLASH_AW'(index_q) << OB) |
                      FLASH_AW'(cnt_q);

        prog_active = rst && (state_q == StProg);
        fl_cs_n     = prog_active ? pg_cs_n : fl_cs_n_i;
        fl_sck      = prog_active ? pg_sck  : fl_sck_i;
        fl_mosi     = prog_active ? pg_mosi : fl_mosi_i;
        pg_miso     = prog_active ? fl_miso : 1'b0;
    end

endmodule

// File: tb/tb_storage_cache_ctrl.sv
// Directed bench for storage_cache_ctrl with SRAM and wishbone flash models.
module tb_storage_cache_ctrl;

    localparam logic [31:0] FB = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        cache_flush, prog_mode, prog_active;
    logic        sram_cen_n, sram_gwen_n;
    logic [3:0]  sram_wen_n;
    logic [10:0] sram_a;
    logic [31:0] sram_d, sram_q;
    logic        wb_cyc, wb_stb, wb_stall;
    logic        wb_ack = 1'b0;
    logic [21:0] wb_addr;
    logic [31:0] wb_data = '0;
    logic        fl_cs_n_i, fl_sck_i, fl_mosi_i, fl_cs_n, fl_sck, fl_mosi, fl_miso;
    logic        pg_cs_n, pg_sck, pg_mosi, pg_miso;

    int nvec = 0;
    int nerr = 0;
    int stb_cnt = 0;
    int cyc_cnt = 0;
    logic [21:0] stb_log [64];
    logic [31:0] mem [2048];

    always #5 clk = ~clk;

    storage_cache_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .cache_flush(cache_flush), .prog_mode(prog_mode), .prog_active(prog_active),
        .sram_cen_n(sram_cen_n), .sram_gwen_n(sram_gwen_n), .sram_wen_n(sram_wen_n),
        .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_addr(wb_addr), .wb_stall(wb_stall),
        .wb_ack(wb_ack), .wb_data(wb_data),
        .fl_cs_n_i(fl_cs_n_i), .fl_sck_i(fl_sck_i), .fl_mosi_i(fl_mosi_i),
        .fl_cs_n(fl_cs_n), .fl_sck(fl_sck), .fl_mosi(fl_mosi), .fl_miso(fl_miso),
        .pg_cs_n(pg_cs_n), .pg_sck(pg_sck), .pg_mosi(pg_mosi), .pg_miso(pg_miso)
    );

    function automatic logic [31:0] flash_word(input logic [21:0] w);
        return 32'hC000_0000 | {10'd0, w};
    endfunction

    always @(posedge clk) begin
        if (!sram_cen_n) begin
            if (!sram_gwen_n) begin
                for (int i = 0; i < 4; i++) begin
                    if (!sram_wen_n[i]) mem[sram_a][i*8 +: 8] <= sram_d[i*8 +: 8];
                end
            end
            sram_q <= mem[sram_a];
        end
    end

    always @(posedge clk) begin
        if (wb_cyc && wb_stb && !wb_stall) begin
            wb_ack              <= 1'b1;
            wb_data             <= flash_word(wb_addr);
            stb_log[stb_cnt%64] <= wb_addr;
            stb_cnt             <= stb_cnt + 1;
        end else begin
            wb_ack <= 1'b0;
        end
        if (wb_cyc) cyc_cnt <= cyc_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, output logic [31:0] rd, output logic er,
                       output int lat);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (resp_valid) break;
        end
        rd = resp_rdata;
        er = resp_err;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat, b, c, n, seen;

        rst = 1'b0; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_be = 0;
        cache_flush = 0; prog_mode = 0; wb_stall = 0;
        fl_cs_n_i = 1; fl_sck_i = 1; fl_mosi_i = 0; fl_miso = 1;
        pg_cs_n = 1; pg_sck = 0; pg_mosi = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_resp", {30'd0, resp_valid, resp_err}, 0);
        chk("rst_wb", {30'd0, wb_cyc, wb_stb}, 0);
        chk("rst_sram", {26'd0, sram_cen_n, sram_gwen_n, sram_wen_n}, 32'h3F);
        chk("rst_prog", {30'd0, prog_active, pg_miso}, 0);
        chk("rst_pins", {29'd0, fl_cs_n, fl_sck, fl_mosi}, 32'b110);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_ready", 32'(req_ready), 1);

        txn(1, 32'h10, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
        chk("sram_wr_lat", lat, 1);
        chk("sram_wr_err", 32'(er), 0);
        txn(0, 32'h10, 0, 4'h0, rd, er, lat);
        chk("sram_rd_lat", lat, 1);
        chk("sram_rd", rd, 32'hDEAD_BEEF);
        txn(1, 32'h10, 32'h0000_AAAA, 4'b0011, rd, er, lat);
        txn(0, 32'h10, 0, 4'h0, rd, er, lat);
        chk("sram_be", rd, 32'hDEAD_AAAA);

        b = stb_cnt;
        txn(0, FB + 32'h4, 0, 0, rd, er, lat);
        chk("cold_data", rd, 32'hC000_0001);
        chk("cold_err", 32'(er), 0);
        chk("cold_lat", 32'(lat >= 9), 1);
        chk("cold_nstb", stb_cnt - b, 4);
        for (int i = 0; i < 4; i++) chk("cold_order", 32'(stb_log[(b+i)%64]), i);
        c = cyc_cnt;
        txn(0, FB + 32'h4, 0, 0, rd, er, lat);
        chk("hit_data", rd, 32'hC000_0001);
        chk("hit_lat", lat, 1);
        chk("hit_nocyc", cyc_cnt - c, 0);

        b = stb_cnt;
        txn(0, FB + 32'h40, 0, 0, rd, er, lat);
        chk("alias_a_data", rd, 32'hC000_0010);
        txn(0, FB + 32'h40, 0, 0, rd, er, lat);
        chk("alias_a_hit", stb_cnt - b, 4);
        txn(0, FB + 32'h140, 0, 0, rd, er, lat);
        chk("alias_b_miss", stb_cnt - b, 8);
        chk("alias_b_data", rd, 32'hC000_0050);
        chk("alias_b_addr", 32'(stb_log[(b+4)%64]), 32'h50);
        txn(0, FB + 32'h40, 0, 0, rd, er, lat);
        chk("alias_a_remiss", stb_cnt - b, 12);
        chk("alias_a_data2", rd, 32'hC000_0010);

        c = cyc_cnt;
        txn(1, FB, 32'h1234_5678, 4'hF, rd, er, lat);
        chk("fl_wr_err", {31'd0, er}, 1);
        chk("fl_wr_data", rd, 0);
        chk("fl_wr_lat", lat, 1);
        chk("fl_wr_nocyc", cyc_cnt - c, 0);
        txn(0, 32'h0000_8000, 0, 0, rd, er, lat);
        chk("unmapped_err", {31'd0, er}, 1);
        chk("unmapped_data", rd, 0);

        @(negedge clk); cache_flush = 1'b1;
        @(negedge clk); cache_flush = 1'b0;
        b = stb_cnt;
        txn(0, FB + 32'h40, 0, 0, rd, er, lat);
        chk("flush_miss", stb_cnt - b, 4);

        @(negedge clk);
        wb_stall = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = FB + 32'h200;
        chk("prog_pre_ready", 32'(req_ready), 1);
        @(posedge clk);
        #1 req_valid = 1'b0; prog_mode = 1'b1;
        repeat (5) @(negedge clk);
        chk("stall_stb", {30'd0, wb_cyc, wb_stb}, 3);
        chk("drain_not_prog", 32'(prog_active), 0);
        wb_stall = 1'b0;
        n = 0;
        while (!resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_resp", 32'(resp_valid), 1);
        chk("drain_data", resp_rdata, 32'hC000_0080);
        n = 0;
        while (!prog_active && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("prog_active", 32'(prog_active), 1);
        chk("prog_ready", 32'(req_ready), 0);
        fl_sck_i = 1'b0; pg_sck = 1'b1;
        #1 chk("prog_sck_hi", 32'(fl_sck), 1);
        pg_sck = 1'b0; fl_sck_i = 1'b1;
        #1 chk("prog_sck_lo", 32'(fl_sck), 0);
        fl_miso = 1'b1;
        #1 chk("prog_miso", 32'(pg_miso), 1);
        @(negedge clk); prog_mode = 1'b0;
        @(negedge clk);
        chk("prog_exit", {30'd0, prog_active, req_ready}, 1);
        b = stb_cnt;
        txn(0, FB + 32'h200, 0, 0, rd, er, lat);
        chk("post_prog_miss", stb_cnt - b, 4);
        chk("post_prog_data", rd, 32'hC000_0080);

        @(negedge clk);
        wb_stall = 1'b1; req_valid = 1'b1; req_addr = FB + 32'h300;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("midfill_cyc", 32'(wb_cyc), 1);
        rst = 1'b0;
        #1 chk("rst_drops_cyc", 32'(wb_cyc), 0);
        wb_stall = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        chk("rst_no_resp", seen, 0);
        b = stb_cnt;
        txn(0, FB + 32'h200, 0, 0, rd, er, lat);
        chk("rst_invalid", stb_cnt - b, 4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
